maze_reader: RTL



---
 rtl/maze_pkg.sv | 27 ++
 rtl/maze_ram.sv | 31 +++
 rtl/maze_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared maze definitions: tile codes, grid geometry and tile-RAM addressing.
// Imported by the display-side reader and the game controller alike.
package maze_pkg;

  localparam int TILE_LOG2 = 5;
  localparam int TILE_SIZE = 32;
  localparam int GRID_W    = 25;
  localparam int GRID_H    = 17;
  localparam int ADDR_W    = 10;
  localparam int CODE_W    = 4;

  typedef enum logic [CODE_W-1:0] {
    WALL_EMPTY  = 4'd0,
    WALL_1      = 4'd1,
    WALL_2      = 4'd2,
    GATE_RIGHT  = 4'd3,
    GATE_LEFT   = 4'd4,
    GATE_UP     = 4'd5,
    GATE_DOWN   = 4'd6
  } tile_code_e;

  // Raster counters stick at full scale instead of wrapping.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/maze_ram.sv
// Maze tile RAM: 1024x4, one controller write port, two synchronous read ports.
// Reads have one cycle of latency; a read of the address being written returns old data.
module maze_ram
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [3:0]        rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [3:0]        rdata_b
);

  logic [3:0] mem_q [1024];
  logic [3:0] rdata_a_q;
  logic [3:0] rdata_b_q;

  always_ff @(posedge clk) begin
    if (we)   mem_q[waddr] <= wdata;
    if (re_a) rdata_a_q    <= mem_q[raddr_a];
    if (re_b) rdata_b_q    <= mem_q[raddr_b];
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: rtl/maze_reader.sv
// Display-side reader of the maze tile RAM: raster tracking, one read per tile span,
// and a 2-cycle pixel-aligned stream of tile code plus in-tile offsets.
module maze_reader
  import maze_pkg::*;
#(
  parameter int TILE_LOG2 = 5,
  parameter int GRID_W    = 25,
  parameter int GRID_H    = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              SOF,
  input  logic              de,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  input  logic [3:0]        ram_rdata,
  output logic              out_de,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic [3:0]        tile_code,
  output logic [4:0]        tile_u,
  output logic [4:0]        tile_v,
  output logic              in_grid
);

  localparam logic [9:0] SCR_W     = 10'(GRID_W << TILE_LOG2);
  localparam logic [9:0] SCR_H     = 10'(GRID_H << TILE_LOG2);
  localparam logic [9:0] SPAN_MASK = 10'((1 << TILE_LOG2) - 1);

  logic [9:0]        x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic              de_dly_q, de_dly_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              in_grid_p0, rd_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic [9:0]        x_p1_q, x_p1_d, y_p1_q, y_p1_d;
  logic              vld_p1_q, vld_p1_d, ing_p1_q, ing_p1_d, rd_p1_q, rd_p1_d;

  logic [9:0]        x_p2_q, x_p2_d, y_p2_q, y_p2_d;
  logic              vld_p2_q, vld_p2_d, ing_p2_q, ing_p2_d;
  logic [3:0]        code_p2_q, code_p2_d;

  always_comb begin
    // Stage 0: raster counters and read issue
    in_grid_p0 = (x_cnt_q < SCR_W) && (y_cnt_q < SCR_H);
    rd_p0      = reset_n && de && in_grid_p0 &&
                 (((x_cnt_q & SPAN_MASK) == '0) || !de_dly_q);
    addr_p0    = {5'(y_cnt_q >> TILE_LOG2), 5'(x_cnt_q >> TILE_LOG2)};
    raddr_d    = rd_p0 ? addr_p0 : raddr_q;
    de_dly_d   = de;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    if (SOF) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (de) begin
      x_cnt_d = sat_inc(x_cnt_q);
    end else if (de_dly_q) begin
      x_cnt_d = '0;
      y_cnt_d = sat_inc(y_cnt_q);
    end

    // Stage 1: RAM data arrives alongside the carried coordinates
    x_p1_d   = x_cnt_q;
    y_p1_d   = y_cnt_q;
    vld_p1_d = de;
    ing_p1_d = in_grid_p0;
    rd_p1_d  = rd_p0;

    // Stage 2: registered outputs; everything holds through blanking
    vld_p2_d  = vld_p1_q;
    x_p2_d    = vld_p1_q ? x_p1_q : x_p2_q;
    y_p2_d    = vld_p1_q ? y_p1_q : y_p2_q;
    ing_p2_d  = vld_p1_q ? ing_p1_q : ing_p2_q;
    code_p2_d = code_p2_q;
    if (vld_p1_q) begin
      if (!ing_p1_q)    code_p2_d = WALL_EMPTY;
      else if (rd_p1_q) code_p2_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      de_dly_q  <= 1'b0;
      raddr_q   <= '0;
      x_p1_q    <= '0;
      y_p1_q    <= '0;
      vld_p1_q  <= 1'b0;
      ing_p1_q  <= 1'b0;
      rd_p1_q   <= 1'b0;
      x_p2_q    <= '0;
      y_p2_q    <= '0;
      vld_p2_q  <= 1'b0;
      ing_p2_q  <= 1'b0;
      code_p2_q <= '0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      de_dly_q  <= de_dly_d;
      raddr_q   <= raddr_d;
      x_p1_q    <= x_p1_d;
      y_p1_q    <= y_p1_d;
      vld_p1_q  <= vld_p1_d;
      ing_p1_q  <= ing_p1_d;
      rd_p1_q   <= rd_p1_d;
      x_p2_q    <= x_p2_d;
      y_p2_q    <= y_p2_d;
      vld_p2_q  <= vld_p2_d;
      ing_p2_q  <= ing_p2_d;
      code_p2_q <= code_p2_d;
    end
  end

  assign ram_re    = rd_p0;
  assign ram_raddr = raddr_d;
  assign out_de    = vld_p2_q;
  assign out_x     = x_p2_q;
  assign out_y     = y_p2_q;
  assign tile_code = code_p2_q;
  assign tile_u    = x_p2_q[4:0];
  assign tile_v    = y_p2_q[4:0];
  assign in_grid   = ing_p2_q;

endmodule
